gcn_buf_fifo_ctrl: RTL

- Control stage that sits directly in front of a floparray instance and turns it into a streaming FIFO for the GCN datapath.
- Accepts a valid/ready write stream from upstream and drives the array's waddr/wen/wdata and raddr/ren ports.
- Captures the array's 1-cycle-late rdata and presents it downstream as a valid/ready stream.
- Hides the array's write-suppressed-during-read rule from both neighbours.

---
 rtl/gcn_buf_fifo_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/gcn_buf_fifo_ctrl.sv
// Streaming FIFO control in front of a 1-cycle-latency floparray. Reads take priority
// on the shared array port; a one-entry hold stage absorbs late downstream backpressure.
module gcn_buf_fifo_ctrl #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    arr_raddr,
    output logic             arr_ren,
    input  logic [WIDTH-1:0] arr_rdata,
    output logic [AW-1:0]    arr_waddr,
    output logic             arr_wen,
    output logic [WIDTH-1:0] arr_wdata,
    output logic [AW:0]      count
);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      mem_cnt;
    logic             inflight;
    logic             hold_v;
    logic [WIDTH-1:0] hold_q;
    logic             rd;
    logic             wr;
    logic             capture;

    assign out_valid = hold_v | inflight;
    assign out_data  = hold_v ? hold_q : arr_rdata;

    // A read issues whenever the output stage will have room for the returning word,
    // and it owns the array that cycle, so upstream is held off.
    assign rd       = (mem_cnt != '0) & (~out_valid | out_ready);
    assign in_ready = ~reset & (mem_cnt < (AW+1)'(DEPTH)) & ~rd;
    assign wr       = in_valid & in_ready;

    // Returning word that downstream refuses is parked so it cannot be lost.
    assign capture  = inflight & ~out_ready & ~hold_v;

    assign arr_ren   = rd;
    assign arr_raddr = rptr;
    assign arr_wen   = wr;
    assign arr_waddr = wptr;
    assign arr_wdata = in_data;

    assign count = mem_cnt + {{AW{1'b0}}, out_valid};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            hold_v   <= 1'b0;
        end else begin
            inflight <= rd;
            if (rd) begin
                rptr    <= rptr + AW'(1);
                mem_cnt <= mem_cnt - (AW+1)'(1);
            end else if (wr) begin
                wptr    <= wptr + AW'(1);
                mem_cnt <= mem_cnt + (AW+1)'(1);
            end
            if (capture) begin
                hold_v <= 1'b1;
            end else if (hold_v && out_ready) begin
                hold_v <= 1'b0;
            end
        end
    end

    // NOTE: hold_q is pure data qualified by hold_v, so it carries no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            hold_q <= arr_rdata;
        end
    end

endmodule
